// File: rtl/sound_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sound_sequencer
// Purpose  : Turns a one-cycle play_sound / sound_code request into a short
//            melody of square-wave notes separated by silent gaps, driving a
//            mono PWM audio pin and an amplifier enable. A new request always
//            preempts the melody in progress.
// Ports    : clk        - system clock
//            rstn       - asynchronous active-low reset
//            sound_code - melody selector, valid while play_sound is high
//            play_sound - one-cycle request pulse
//            audio_pwm  - square-wave audio output (registered)
//            audio_sd   - amplifier enable, high during notes and gaps
//            busy       - high while a melody is in progress
// Revision : 1.0 - initial release
// ============================================================================
module sound_sequencer #(
  parameter int CLK_HZ = 100_000_000,
  parameter int GAP_MS = 10
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] sound_code,
  input  logic       play_sound,
  output logic       audio_pwm,
  output logic       audio_sd,
  output logic       busy
);

  // Half-period in cycles for a given tone, never below one cycle.
  function automatic int half_of(input int clk_hz, input int freq_hz);
    int h;
    h = clk_hz / (2 * freq_hz);
    return (h < 1) ? 1 : h;
  endfunction

  localparam int MS     = CLK_HZ / 1000;
  // Duration counter is shared by notes and gaps, so size it for the longer.
  localparam int MAX_MS = (GAP_MS > 240) ? GAP_MS : 240;
  localparam int DUR_W  = $clog2(MAX_MS * MS + 1);
  // 220 Hz is the lowest tone, hence the longest half period.
  localparam int HALF_W = $clog2(half_of(CLK_HZ, 220) + 1);

  localparam logic [HALF_W-1:0] H_220  = HALF_W'(half_of(CLK_HZ, 220));
  localparam logic [HALF_W-1:0] H_523  = HALF_W'(half_of(CLK_HZ, 523));
  localparam logic [HALF_W-1:0] H_659  = HALF_W'(half_of(CLK_HZ, 659));
  localparam logic [HALF_W-1:0] H_784  = HALF_W'(half_of(CLK_HZ, 784));
  localparam logic [HALF_W-1:0] H_1047 = HALF_W'(half_of(CLK_HZ, 1047));
  localparam logic [HALF_W-1:0] H_1319 = HALF_W'(half_of(CLK_HZ, 1319));

  localparam logic [DUR_W-1:0] D_40    = DUR_W'(40 * MS);
  localparam logic [DUR_W-1:0] D_50    = DUR_W'(50 * MS);
  localparam logic [DUR_W-1:0] D_60    = DUR_W'(60 * MS);
  localparam logic [DUR_W-1:0] D_120   = DUR_W'(120 * MS);
  localparam logic [DUR_W-1:0] D_150   = DUR_W'(150 * MS);
  localparam logic [DUR_W-1:0] D_240   = DUR_W'(240 * MS);
  localparam logic [DUR_W-1:0] GAP_CYC = DUR_W'(GAP_MS * MS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          code_q, code_d;
  logic [1:0]          idx_q, idx_d;
  logic [HALF_W-1:0]   half_cnt_q, half_cnt_d;
  logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
  logic                pwm_q, pwm_d;
  logic                sd_q, sd_d;
  logic                busy_q, busy_d;

  logic [HALF_W-1:0]   cur_half;
  logic [DUR_W-1:0]    cur_dur;
  logic                cur_last;
  logic                code_valid;

  assign code_valid = (sound_code != 3'd0) && (sound_code <= 3'd4);

  // Melody ROM: half period, length and last-note flag for the current note.
  always_comb begin
    cur_half = H_1319;
    cur_dur  = D_50;
    cur_last = 1'b1;
    case ({code_q, idx_q})
      5'b001_00: begin cur_half = H_1319; cur_dur = D_50;  cur_last = 1'b1; end
      5'b010_00: begin cur_half = H_784;  cur_dur = D_40;  cur_last = 1'b0; end
      5'b010_01: begin cur_half = H_1047; cur_dur = D_60;  cur_last = 1'b1; end
      5'b011_00: begin cur_half = H_523;  cur_dur = D_120; cur_last = 1'b0; end
      5'b011_01: begin cur_half = H_659;  cur_dur = D_120; cur_last = 1'b0; end
      5'b011_10: begin cur_half = H_784;  cur_dur = D_120; cur_last = 1'b0; end
      5'b011_11: begin cur_half = H_1047; cur_dur = D_240; cur_last = 1'b1; end
      5'b100_00: begin cur_half = H_220;  cur_dur = D_150; cur_last = 1'b1; end
      default:   begin end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    idx_d      = idx_q;
    half_cnt_d = half_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    pwm_d      = pwm_q;
    sd_d       = sd_q;
    busy_d     = busy_q;

    if (play_sound) begin
      // Any request discards the current melody; silent codes simply stop.
      half_cnt_d = '0;
      dur_cnt_d  = '0;
      idx_d      = 2'd0;
      pwm_d      = 1'b0;
      if (code_valid) begin
        state_d = TONE;
        code_d  = sound_code;
        sd_d    = 1'b1;
        busy_d  = 1'b1;
      end else begin
        state_d = IDLE;
        sd_d    = 1'b0;
        busy_d  = 1'b0;
      end
    end else begin
      case (state_q)
        TONE: begin
          if (dur_cnt_q == cur_dur - DUR_W'(1)) begin
            half_cnt_d = '0;
            dur_cnt_d  = '0;
            pwm_d      = 1'b0;
            if (cur_last) begin
              state_d = IDLE;
              sd_d    = 1'b0;
              busy_d  = 1'b0;
            end else begin
              state_d = GAP;
            end
          end else begin
            dur_cnt_d = dur_cnt_q + DUR_W'(1);
            if (half_cnt_q == cur_half - HALF_W'(1)) begin
              half_cnt_d = '0;
              pwm_d      = ~pwm_q;
            end else begin
              half_cnt_d = half_cnt_q + HALF_W'(1);
            end
          end
        end
        GAP: begin
          pwm_d = 1'b0;
          if (dur_cnt_q == GAP_CYC - DUR_W'(1)) begin
            state_d    = TONE;
            idx_d      = idx_q + 2'd1;
            dur_cnt_d  = '0;
            half_cnt_d = '0;
          end else begin
            dur_cnt_d = dur_cnt_q + DUR_W'(1);
          end
        end
        default: begin
          state_d    = IDLE;
          half_cnt_d = '0;
          dur_cnt_d  = '0;
          pwm_d      = 1'b0;
          sd_d       = 1'b0;
          busy_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      code_q     <= 3'd0;
      idx_q      <= 2'd0;
      half_cnt_q <= '0;
      dur_cnt_q  <= '0;
      pwm_q      <= 1'b0;
      sd_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      idx_q      <= idx_d;
      half_cnt_q <= half_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      pwm_q      <= pwm_d;
      sd_q       <= sd_d;
      busy_q     <= busy_d;
    end
  end

  assign audio_pwm = pwm_q;
  assign audio_sd  = sd_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sound_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_sequencer
// Purpose  : Directed self-checking bench for sound_sequencer at
//            CLK_HZ=100_000 (100 cycles per ms) and GAP_MS=10.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sound_sequencer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] sound_code = 3'd0;
  logic       play_sound = 1'b0;
  logic       audio_pwm;
  logic       audio_sd;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

  sound_sequencer #(
    .CLK_HZ (100_000),
    .GAP_MS (10)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sound_code (sound_code),
    .play_sound (play_sound),
    .audio_pwm  (audio_pwm),
    .audio_sd   (audio_sd),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (120000) @(posedge clk);
    $display("FAIL watchdog: simulation still running after 120000 cycles, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Advance to just after the next rising edge, where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [2:0] code);
    sound_code = code;
    play_sound = 1'b1;
    tick();
    play_sound = 1'b0;
    sound_code = 3'd0;
  endtask

  task automatic test_reset();
    logic bad;
    rstn = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({busy, audio_sd, audio_pwm} !== 3'b000) begin
      $display("FAIL reset_hold: got %b expected 000", {busy, audio_sd, audio_pwm});
      tests_failed++;
    end
    @(negedge clk);
    rstn = 1'b1;
    tick();
    bad = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if ({busy, audio_sd, audio_pwm} !== 3'b000 && !bad) begin
        $display("FAIL idle_quiet: cycle %0d got %b expected 000", k, {busy, audio_sd, audio_pwm});
        bad = 1'b1;
      end
      tick();
    end
    tests_run++;
    if (bad) tests_failed++;
  endtask

  task automatic test_code1();
    logic bad;
    logic [2:0] exp;
    // Request visible but not yet clocked: no combinational path to busy.
    sound_code = 3'd1;
    play_sound = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0) begin
      $display("FAIL code1_no_comb: busy=%b expected 0 before clock edge", busy);
      tests_failed++;
    end
    tick();
    play_sound = 1'b0;
    sound_code = 3'd0;
    bad = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      exp = {2'b11, ((k / 37) % 2) == 1};
      if ({busy, audio_sd, audio_pwm} !== exp && !bad) begin
        $display("FAIL code1_tone: cycle %0d got %b expected %b", k, {busy, audio_sd, audio_pwm}, exp);
        bad = 1'b1;
      end
      tick();
    end
    tests_run++;
    if (bad) tests_failed++;
    bad = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if ({busy, audio_sd, audio_pwm} !== 3'b000 && !bad) begin
        $display("FAIL code1_end: cycle %0d got %b expected 000", k, {busy, audio_sd, audio_pwm});
        bad = 1'b1;
      end
      tick();
    end
    tests_run++;
    if (bad) tests_failed++;
  endtask

  task automatic test_code2();
    logic bad;
    logic [2:0] exp;
    int hv[2];
    int dv[2];
    hv = '{63, 47};
    dv = '{4000, 6000};
    request(3'd2);
    for (int n = 0; n < 2; n++) begin
      bad = 1'b0;
      for (int k = 0; k < dv[n]; k++) begin
        exp = {2'b11, ((k / hv[n]) % 2) == 1};
        if ({busy, audio_sd, audio_pwm} !== exp && !bad) begin
          $display("FAIL code2_tone%0d: cycle %0d got %b expected %b", n, k, {busy, audio_sd, audio_pwm}, exp);
          bad = 1'b1;
        end
        tick();
      end
      tests_run++;
      if (bad) tests_failed++;
      if (n < 1) begin
        bad = 1'b0;
        for (int k = 0; k < 1000; k++) begin
          if ({busy, audio_sd, audio_pwm} !== 3'b110 && !bad) begin
            $display("FAIL code2_gap: cycle %0d got %b expected 110", k, {busy, audio_sd, audio_pwm});
            bad = 1'b1;
          end
          tick();
        end
        tests_run++;
        if (bad) tests_failed++;
      end
    end
    tests_run++;
    if ({busy, audio_sd, audio_pwm} !== 3'b000) begin
      $display("FAIL code2_end: got %b expected 000", {busy, audio_sd, audio_pwm});
      tests_failed++;
    end
    repeat (20) tick();
  endtask

  task automatic test_code3();
    logic bad;
    logic [2:0] exp;
    int hv[4];
    int dv[4];
    hv = '{95, 75, 63, 47};
    dv = '{12000, 12000, 12000, 24000};
    request(3'd3);
    for (int n = 0; n < 4; n++) begin
      bad = 1'b0;
      for (int k = 0; k < dv[n]; k++) begin
        exp = {2'b11, ((k / hv[n]) % 2) == 1};
        if ({busy, audio_sd, audio_pwm} !== exp && !bad) begin
          $display("FAIL code3_tone%0d: cycle %0d got %b expected %b", n, k, {busy, audio_sd, audio_pwm}, exp);
          bad = 1'b1;
        end
        tick();
      end
      tests_run++;
      if (bad) tests_failed++;
      if (n < 3) begin
        bad = 1'b0;
        for (int k = 0; k < 1000; k++) begin
          if ({busy, audio_sd, audio_pwm} !== 3'b110 && !bad) begin
            $display("FAIL code3_gap%0d: cycle %0d got %b expected 110", n, k, {busy, audio_sd, audio_pwm});
            bad = 1'b1;
          end
          tick();
        end
        tests_run++;
        if (bad) tests_failed++;
      end
    end
    tests_run++;
    if ({busy, audio_sd, audio_pwm} !== 3'b000) begin
      $display("FAIL code3_end: got %b expected 000", {busy, audio_sd, audio_pwm});
      tests_failed++;
    end
    repeat (20) tick();
  endtask

  task automatic test_back_to_back();
    logic bad;
    logic [2:0] exp;
    request(3'd2);
    bad = 1'b0;
    for (int k = 0; k < 2500; k++) begin
      exp = {2'b11, ((k / 63) % 2) == 1};
      if ({busy, audio_sd, audio_pwm} !== exp && !bad) begin
        $display("FAIL preempt_first: cycle %0d got %b expected %b", k, {busy, audio_sd, audio_pwm}, exp);
        bad = 1'b1;
      end
      tick();
    end
    tests_run++;
    if (bad) tests_failed++;
    tests_run++;
    if (busy !== 1'b1) begin
      $display("FAIL preempt_busy_before: got %b expected 1", busy);
      tests_failed++;
    end
    request(3'd1);
    bad = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      exp = {2'b11, ((k / 37) % 2) == 1};
      if ({busy, audio_sd, audio_pwm} !== exp && !bad) begin
        $display("FAIL preempt_second: cycle %0d got %b expected %b", k, {busy, audio_sd, audio_pwm}, exp);
        bad = 1'b1;
      end
      tick();
    end
    tests_run++;
    if (bad) tests_failed++;
    tests_run++;
    if ({busy, audio_sd, audio_pwm} !== 3'b000) begin
      $display("FAIL preempt_end: got %b expected 000", {busy, audio_sd, audio_pwm});
      tests_failed++;
    end
    repeat (10) tick();
  endtask

  task automatic test_stop();
    logic bad;
    logic [2:0] exp;
    // Silent code from idle: nothing starts.
    request(3'd5);
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if ({busy, audio_sd, audio_pwm} !== 3'b000 && !bad) begin
        $display("FAIL silent_code: cycle %0d got %b expected 000", k, {busy, audio_sd, audio_pwm});
        bad = 1'b1;
      end
      tick();
    end
    tests_run++;
    if (bad) tests_failed++;
    request(3'd3);
    bad = 1'b0;
    for (int k = 0; k < 500; k++) begin
      exp = {2'b11, ((k / 95) % 2) == 1};
      if ({busy, audio_sd, audio_pwm} !== exp && !bad) begin
        $display("FAIL stop_playing: cycle %0d got %b expected %b", k, {busy, audio_sd, audio_pwm}, exp);
        bad = 1'b1;
      end
      tick();
    end
    tests_run++;
    if (bad) tests_failed++;
    request(3'd0);
    bad = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if ({busy, audio_sd, audio_pwm} !== 3'b000 && !bad) begin
        $display("FAIL stop_idle: cycle %0d got %b expected 000", k, {busy, audio_sd, audio_pwm});
        bad = 1'b1;
      end
      tick();
    end
    tests_run++;
    if (bad) tests_failed++;
  endtask

  task automatic test_async_reset();
    logic bad;
    request(3'd3);
    repeat (500) tick();
    // 500 cycles into a HALF=95 note: pwm is in its high phase.
    tests_run++;
    if ({busy, audio_sd, audio_pwm} !== 3'b111) begin
      $display("FAIL areset_pre: got %b expected 111", {busy, audio_sd, audio_pwm});
      tests_failed++;
    end
    #2;
    rstn = 1'b0;
    #1;
    tests_run++;
    if ({busy, audio_sd, audio_pwm} !== 3'b000) begin
      $display("FAIL areset_immediate: got %b expected 000", {busy, audio_sd, audio_pwm});
      tests_failed++;
    end
    tick();
    tick();
    #2;
    rstn = 1'b1;
    tick();
    bad = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if ({busy, audio_sd, audio_pwm} !== 3'b000 && !bad) begin
        $display("FAIL areset_after: cycle %0d got %b expected 000", k, {busy, audio_sd, audio_pwm});
        bad = 1'b1;
      end
      tick();
    end
    tests_run++;
    if (bad) tests_failed++;
  endtask

  initial begin
    test_reset();
    test_code1();
    test_code2();
    test_code3();
    test_back_to_back();
    test_stop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
